// File: rtl/fechadura_pkg.sv
// Shared types and constants for the electronic lock.
// Used by the keypad decoder and the password checker.
package fechadura_pkg;

  localparam int N_DIGITOS = 20;
  localparam int LW = $clog2(N_DIGITOS + 1);

  typedef struct packed {
    logic [N_DIGITOS-1:0][3:0] digits;
  } senhaPac_t;

  localparam logic [3:0] DIGITO_VAZIO    = 4'hF;
  localparam logic [3:0] DIGITO_EXPIRADO = 4'hE;
  localparam logic [3:0] DIGITO_LIMPAR   = 4'hB;
  localparam logic [3:0] DIGITO_CONFIRMA = 4'hA;

  typedef enum logic [1:0] {
    FECHADA,
    VERIFICAR,
    ABERTA,
    BLOQUEADA
  } estado_t;

  typedef enum logic [1:0] {
    EV_CONFIRMA,
    EV_LIMPAR,
    EV_EXPIRADO
  } evento_t;

endpackage

// File: rtl/verificador_de_senha_if.sv
// Digit-buffer event channel from the keypad decoder.
// The decoder drives it; the checker consumes it.
interface verificador_de_senha_if;
  import fechadura_pkg::*;

  senhaPac_t digitos_value;
  logic      digitos_valid;

  modport master (
    output digitos_value,
    output digitos_valid
  );

  modport slave (
    input digitos_value,
    input digitos_valid
  );

endinterface

// File: rtl/analisador_de_entrada.sv
// Classifies a digit buffer: event kind, length,
// and whether it is a well-formed password.
module analisador_de_entrada
  import fechadura_pkg::*;
#(
  parameter int MIN_DIGITOS = 4,
  parameter int MAX_DIGITOS = 12
) (
  input  senhaPac_t         entrada_i,
  output evento_t           evento_o,
  output logic [LW-1:0]     len_o,
  output logic              bem_formado_o
);

  logic todos_e;
  logic todos_b;
  logic fim;
  logic cauda_ok;
  logic numeros_ok;
  logic [LW-1:0] len;

  always_comb begin
    todos_e    = 1'b1;
    todos_b    = 1'b1;
    fim        = 1'b0;
    cauda_ok   = 1'b1;
    numeros_ok = 1'b1;
    len        = '0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (entrada_i.digits[i] != DIGITO_EXPIRADO)
        todos_e = 1'b0;
      if (entrada_i.digits[i] != DIGITO_LIMPAR)
        todos_b = 1'b0;
      if (!fim && entrada_i.digits[i] != DIGITO_VAZIO) begin
        len = len + LW'(1);
        if (entrada_i.digits[i] > 4'd9)
          numeros_ok = 1'b0;
      end else begin
        fim = 1'b1;
        // anything typed after the first gap is garbage
        if (entrada_i.digits[i] != DIGITO_VAZIO)
          cauda_ok = 1'b0;
      end
    end
  end

  always_comb begin
    evento_o = EV_CONFIRMA;
    unique case (1'b1)
      todos_e: evento_o = EV_EXPIRADO;
      todos_b: evento_o = EV_LIMPAR;
      default: evento_o = EV_CONFIRMA;
    endcase
  end

  assign len_o = len;
  assign bem_formado_o = cauda_ok && numeros_ok
                      && len >= LW'(MIN_DIGITOS)
                      && len <= LW'(MAX_DIGITOS);

endmodule

// File: rtl/verificador_de_senha.sv
// Password check, lock actuator, retry lockout and
// reprogramming for the electronic lock.
module verificador_de_senha
  import fechadura_pkg::*;
#(
  parameter senhaPac_t SENHA_PADRAO =
    senhaPac_t'(80'hFFFF_FFFF_FFFF_FFFF_1234),
  parameter int MAX_TENTATIVAS = 3,
  parameter int T_ABERTA       = 5000,
  parameter int T_BLOQUEIO     = 30000,
  parameter int MIN_DIGITOS    = 4,
  parameter int MAX_DIGITOS    = 12,
  localparam int CW = $clog2(MAX_TENTATIVAS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  verificador_de_senha_if.slave digitos,
  input  logic                  prog,
  output logic                  teclado_enable,
  output logic                  tranca,
  output logic                  senha_ok,
  output logic                  senha_erro,
  output logic                  senha_nova,
  output logic                  bloqueado,
  output logic [CW-1:0]         tentativas
);

  localparam int T_MAX =
    (T_ABERTA > T_BLOQUEIO) ? T_ABERTA : T_BLOQUEIO;
  localparam int TW = $clog2(T_MAX + 1);

  estado_t       estado_q;
  senhaPac_t     senha_q;
  senhaPac_t     entrada_q;
  logic          bf_q;
  logic          pend_q;
  logic [TW-1:0] timer_q;
  logic [CW-1:0] tent_q;
  logic          tranca_q;
  logic          teclado_q;
  logic          bloq_q;
  logic          ok_q;
  logic          erro_q;
  logic          nova_q;

  evento_t       evento;
  logic [LW-1:0] len;
  logic          bf;

  analisador_de_entrada #(
    .MIN_DIGITOS (MIN_DIGITOS),
    .MAX_DIGITOS (MAX_DIGITOS)
  ) u_analisador (
    .entrada_i     (digitos.digitos_value),
    .evento_o      (evento),
    .len_o         (len),
    .bem_formado_o (bf)
  );

  logic          confirma;
  logic          match;
  logic          expira;
  logic [CW-1:0] tent_d;

  assign confirma = digitos.digitos_valid
                 && evento == EV_CONFIRMA
                 && len != '0;
  assign match  = bf_q && (entrada_q == senha_q);
  assign expira = timer_q <= TW'(1);
  assign tent_d = tent_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= FECHADA;
      senha_q   <= SENHA_PADRAO;
      entrada_q <= SENHA_PADRAO;
      bf_q      <= 1'b0;
      pend_q    <= 1'b0;
      timer_q   <= '0;
      tent_q    <= '0;
      tranca_q  <= 1'b1;
      teclado_q <= 1'b1;
      bloq_q    <= 1'b0;
      ok_q      <= 1'b0;
      erro_q    <= 1'b0;
      nova_q    <= 1'b0;
    end else begin
      ok_q    <= 1'b0;
      erro_q  <= 1'b0;
      nova_q  <= 1'b0;
      timer_q <= (timer_q != '0) ? timer_q - TW'(1) : '0;
      unique case (estado_q)
        FECHADA: begin
          // one-cycle hold before compare keeps outputs at N+2
          if (pend_q) begin
            pend_q   <= 1'b0;
            estado_q <= VERIFICAR;
          end else if (confirma) begin
            entrada_q <= digitos.digitos_value;
            bf_q      <= bf;
            pend_q    <= 1'b1;
          end
        end
        VERIFICAR: begin
          if (match) begin
            ok_q     <= 1'b1;
            tent_q   <= '0;
            timer_q  <= TW'(T_ABERTA);
            tranca_q <= 1'b0;
            estado_q <= ABERTA;
          end else begin
            erro_q <= 1'b1;
            tent_q <= tent_d;
            if (tent_d == CW'(MAX_TENTATIVAS)) begin
              timer_q   <= TW'(T_BLOQUEIO);
              bloq_q    <= 1'b1;
              teclado_q <= 1'b0;
              estado_q  <= BLOQUEADA;
            end else begin
              estado_q <= FECHADA;
            end
          end
        end
        ABERTA: begin
          if (confirma && prog && bf) begin
            senha_q <= digitos.digitos_value;
            nova_q  <= 1'b1;
          end else if (confirma && prog) begin
            erro_q <= 1'b1;
          end
          if ((confirma && (!prog || bf)) || expira) begin
            timer_q  <= '0;
            tranca_q <= 1'b1;
            estado_q <= FECHADA;
          end
        end
        BLOQUEADA: begin
          if (expira) begin
            timer_q   <= '0;
            tent_q    <= '0;
            bloq_q    <= 1'b0;
            teclado_q <= 1'b1;
            estado_q  <= FECHADA;
          end
        end
        default: estado_q <= FECHADA;
      endcase
    end
  end

  assign teclado_enable = teclado_q;
  assign tranca         = tranca_q;
  assign senha_ok       = ok_q;
  assign senha_erro     = erro_q;
  assign senha_nova     = nova_q;
  assign bloqueado      = bloq_q;
  assign tentativas     = tent_q;

endmodule

// File: tb/tb_verificador_de_senha.sv
// Directed bench for verificador_de_senha: open, lockout,
// reprogramming, malformed entries, idle events, reset.
module tb_verificador_de_senha;
  import fechadura_pkg::*;

  localparam senhaPac_t P1234 =
    senhaPac_t'(80'hFFFF_FFFF_FFFF_FFFF_1234);
  localparam senhaPac_t P9999 =
    senhaPac_t'(80'hFFFF_FFFF_FFFF_FFFF_9999);
  localparam senhaPac_t P567890 =
    senhaPac_t'(80'hFFFF_FFFF_FFFF_FF56_7890);
  localparam senhaPac_t P12 =
    senhaPac_t'(80'hFFFF_FFFF_FFFF_FFFF_FF12);
  localparam senhaPac_t PC1234 =
    senhaPac_t'(80'hFFFF_FFFF_FFFF_FFFC_1234);
  localparam senhaPac_t P13 =
    senhaPac_t'(80'hFFFF_FFF1_2345_6789_0123);
  localparam senhaPac_t TODO_B = senhaPac_t'({20{4'hB}});
  localparam senhaPac_t TODO_E = senhaPac_t'({20{4'hE}});
  localparam senhaPac_t TODO_F = senhaPac_t'({20{4'hF}});

  logic       clk = 1'b0;
  logic       rst;
  logic       prog;
  logic       teclado_enable;
  logic       tranca;
  logic       senha_ok;
  logic       senha_erro;
  logic       senha_nova;
  logic       bloqueado;
  logic [1:0] tentativas;

  verificador_de_senha_if dif ();

  verificador_de_senha dut (
    .clk            (clk),
    .rst            (rst),
    .digitos        (dif),
    .prog           (prog),
    .teclado_enable (teclado_enable),
    .tranca         (tranca),
    .senha_ok       (senha_ok),
    .senha_erro     (senha_erro),
    .senha_nova     (senha_nova),
    .bloqueado      (bloqueado),
    .tentativas     (tentativas)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp_v);
    end
  endtask

  // valid high for one cycle, sampled at the next posedge
  task automatic enviar(input senhaPac_t v,
                        input logic p);
    @(negedge clk);
    dif.digitos_value = v;
    dif.digitos_valid = 1'b1;
    prog = p;
    @(negedge clk);
    dif.digitos_valid = 1'b0;
    prog = 1'b0;
  endtask

  task automatic abrir(input senhaPac_t v);
    enviar(v, 1'b0);
    @(negedge clk);
    chk("ok_latencia", senha_ok, 0);
    chk("tranca_latencia", tranca, 1);
    @(negedge clk);
    chk("ok_abre", senha_ok, 1);
    chk("tranca_abre", tranca, 0);
    chk("tent_abre", tentativas, 0);
  endtask

  senhaPac_t ociosos[3];
  int        cnt;
  logic      viu_ok;

  initial begin
    rst = 1'b1;
    prog = 1'b0;
    dif.digitos_valid = 1'b0;
    dif.digitos_value = TODO_F;
    repeat (3) @(negedge clk);
    chk("rst_tranca", tranca, 1);
    chk("rst_teclado", teclado_enable, 1);
    chk("rst_bloq", bloqueado, 0);
    chk("rst_tent", tentativas, 0);
    chk("rst_ok", senha_ok, 0);
    chk("rst_erro", senha_erro, 0);
    chk("rst_nova", senha_nova, 0);
    rst = 1'b0;

    // open with the default password and time the open window
    abrir(P1234);
    @(negedge clk);
    chk("ok_pulso", senha_ok, 0);
    cnt = 2;
    while (tranca === 1'b0 && cnt < 6000) begin
      @(negedge clk);
      if (tranca === 1'b0) cnt++;
    end
    chk("t_aberta", cnt, 5000);

    // three wrong attempts lead to lockout
    for (int k = 1; k <= 3; k++) begin
      enviar(P9999, 1'b0);
      repeat (2) @(negedge clk);
      chk("erro_errada", senha_erro, 1);
      chk("tent_conta", tentativas, k);
    end
    chk("bloq_ativo", bloqueado, 1);
    chk("teclado_off", teclado_enable, 0);
    cnt = 1;
    viu_ok = 1'b0;
    while (bloqueado === 1'b1 && cnt < 31000) begin
      @(negedge clk);
      dif.digitos_value = P1234;
      dif.digitos_valid = (cnt == 10);
      if (senha_ok === 1'b1) viu_ok = 1'b1;
      if (bloqueado === 1'b1) cnt++;
    end
    dif.digitos_valid = 1'b0;
    chk("t_bloqueio", cnt, 30000);
    chk("teclado_volta", teclado_enable, 1);
    chk("tent_zera", tentativas, 0);
    chk("bloq_ignora", viu_ok, 0);

    // reprogram while open
    abrir(P1234);
    enviar(P567890, 1'b1);
    chk("nova_pulso", senha_nova, 1);
    chk("nova_tranca", tranca, 1);
    @(negedge clk);
    chk("nova_fim", senha_nova, 0);
    enviar(P1234, 1'b0);
    repeat (2) @(negedge clk);
    chk("velha_rejeitada", senha_erro, 1);
    chk("velha_tent", tentativas, 1);
    enviar(P567890, 1'b0);
    repeat (2) @(negedge clk);
    chk("nova_aceita", senha_ok, 1);
    chk("nova_tent", tentativas, 0);

    // malformed programming attempts stay open
    enviar(P12, 1'b1);
    chk("curta_erro", senha_erro, 1);
    chk("curta_aberta", tranca, 0);
    chk("curta_tent", tentativas, 0);
    chk("curta_nova", senha_nova, 0);
    enviar(PC1234, 1'b1);
    chk("nao_digito_erro", senha_erro, 1);
    enviar(P13, 1'b1);
    chk("longa_erro", senha_erro, 1);
    chk("longa_aberta", tranca, 0);
    enviar(TODO_B, 1'b1);
    chk("limpar_aberta", tranca, 0);
    chk("limpar_erro", senha_erro, 0);
    enviar(P1234, 1'b0);
    chk("fecha_agora", tranca, 1);
    chk("fecha_erro", senha_erro, 0);
    abrir(P567890);
    enviar(P1234, 1'b0);
    chk("fecha2", tranca, 1);

    // clear / timeout / empty are no-ops when closed
    ociosos[0] = TODO_B;
    ociosos[1] = TODO_E;
    ociosos[2] = TODO_F;
    for (int i = 0; i < 3; i++) begin
      enviar(ociosos[i], 1'b0);
      repeat (2) @(negedge clk);
      chk("ocioso_erro", senha_erro, 0);
      chk("ocioso_ok", senha_ok, 0);
      chk("ocioso_tent", tentativas, 0);
    end

    // reset while open restores the default password
    abrir(P567890);
    repeat (2500) @(negedge clk);
    chk("meio_aberta", tranca, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_fecha", tranca, 1);
    chk("rst_tent2", tentativas, 0);
    enviar(P1234, 1'b0);
    repeat (2) @(negedge clk);
    chk("senha_padrao", senha_ok, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
